// File: rtl/awgn_clt_gen.sv
// Multi-channel AWGN source: per-channel Galois LFSR uniforms summed over SUM_TERMS draws
// (central limit), centred, gain-shifted and saturated, with a valid/ready output stage.
module awgn_clt_gen #(
  parameter int NUM_CH    = 2,
  parameter int OUT_W     = 16,
  parameter int U_W       = 12,
  parameter int SUM_TERMS = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     enable,
  input  logic                     seed_load,
  input  logic [31:0]              seed,
  input  logic [2:0]               scale_shift,
  input  logic                     out_ready,
  output logic                     out_valid,
  output logic [NUM_CH*OUT_W-1:0]  x,
  output logic [NUM_CH-1:0]        sat
);

  localparam int LOG2_T = $clog2(SUM_TERMS);
  localparam int ACC_W  = U_W + LOG2_T;
  localparam int CEN_W  = ACC_W + 1;
  localparam int G_W    = CEN_W + 7;
  localparam int CMP_W  = ((G_W > OUT_W) ? G_W : OUT_W) + 1;
  localparam int CNT_W  = (LOG2_T > 0) ? LOG2_T : 1;

  localparam logic [31:0] GOLDEN   = 32'h9E37_79B9;
  localparam logic [31:0] RST_BASE = 32'hACE1_0001;
  localparam logic [31:0] POLY     = 32'h8020_0003;
  localparam logic [CEN_W-1:0] MID = CEN_W'(64'(SUM_TERMS) << (U_W - 1));
  localparam logic signed [CMP_W-1:0] X_MAX = $signed({{(CMP_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}});
  localparam logic signed [CMP_W-1:0] X_MIN = $signed({{(CMP_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}});

  typedef enum logic [1:0] {IDLE, ACCUM, HOLD} state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             valid_q, valid_d;
  logic             clr_acc;
  logic             run;
  logic             conv;
  logic             last_term;

  assign last_term = (cnt_q == CNT_W'(SUM_TERMS - 1));
  assign out_valid = valid_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    valid_d = valid_q;
    clr_acc = 1'b0;
    run     = 1'b0;
    conv    = 1'b0;
    if (seed_load) begin
      state_d = IDLE;
      cnt_d   = '0;
      valid_d = 1'b0;
      clr_acc = 1'b1;
    end else begin
      case (state_q)
        IDLE: begin
          cnt_d   = '0;
          clr_acc = 1'b1;
          if (enable) state_d = ACCUM;
        end
        ACCUM: begin
          if (!enable) begin
            // Abort: the partial sum is discarded and the LFSRs keep their position.
            state_d = IDLE;
            cnt_d   = '0;
            clr_acc = 1'b1;
          end else begin
            run   = 1'b1;
            cnt_d = cnt_q + CNT_W'(1);
            if (last_term) begin
              conv    = 1'b1;
              valid_d = 1'b1;
              state_d = HOLD;
              cnt_d   = '0;
              clr_acc = 1'b1;
            end
          end
        end
        HOLD: begin
          if (valid_q && out_ready) begin
            valid_d = 1'b0;
            state_d = enable ? ACCUM : IDLE;
            cnt_d   = '0;
            clr_acc = 1'b1;
          end
        end
        default: begin
          state_d = IDLE;
          cnt_d   = '0;
          valid_d = 1'b0;
          clr_acc = 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      valid_q <= valid_d;
    end
  end

  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
    localparam logic [31:0] CH_K = 32'(gi) * GOLDEN;

    logic [31:0]              lfsr_q, lfsr_d;
    logic [ACC_W-1:0]         acc_q, acc_d;
    logic [OUT_W-1:0]         x_ch_q;
    logic                     sat_ch_q;
    logic [31:0]              seed_mix;
    logic [31:0]              lfsr_step;
    logic [U_W-1:0]           u;
    logic [ACC_W-1:0]         sum;
    logic signed [CEN_W-1:0]  cen;
    logic signed [G_W-1:0]    g;
    logic signed [CMP_W-1:0]  g_w;
    logic [OUT_W-1:0]         x_d;
    logic                     sat_d;

    assign seed_mix  = seed ^ CH_K;
    assign lfsr_step = {1'b0, lfsr_q[31:1]} ^ (lfsr_q[0] ? POLY : 32'h0);
    assign u         = lfsr_q[31 -: U_W];
    assign sum       = acc_q + ACC_W'(u);
    assign cen       = $signed({1'b0, sum}) - $signed(MID);
    assign g         = $signed({{7{cen[CEN_W-1]}}, cen}) <<< scale_shift;
    assign g_w       = $signed({{(CMP_W-G_W){g[G_W-1]}}, g});

    always_comb begin
      x_d   = g_w[OUT_W-1:0];
      sat_d = 1'b0;
      if (g_w > X_MAX) begin
        x_d   = {1'b0, {(OUT_W-1){1'b1}}};
        sat_d = 1'b1;
      end else if (g_w < X_MIN) begin
        x_d   = {1'b1, {(OUT_W-1){1'b0}}};
        sat_d = 1'b1;
      end
    end

    always_comb begin
      lfsr_d = lfsr_q;
      acc_d  = acc_q;
      if (seed_load) begin
        // An all-zero LFSR would lock up, so a zero seed maps to 1.
        lfsr_d = (seed_mix == 32'h0) ? 32'h1 : seed_mix;
      end else if (run) begin
        lfsr_d = lfsr_step;
      end
      if (clr_acc) acc_d = '0;
      else if (run) acc_d = sum;
    end

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        lfsr_q   <= RST_BASE ^ CH_K;
        acc_q    <= '0;
        x_ch_q   <= '0;
        sat_ch_q <= 1'b0;
      end else begin
        lfsr_q <= lfsr_d;
        acc_q  <= acc_d;
        if (conv) begin
          x_ch_q   <= x_d;
          sat_ch_q <= sat_d;
        end
      end
    end

    assign x[gi*OUT_W +: OUT_W] = x_ch_q;
    assign sat[gi]              = sat_ch_q;
  end

endmodule
